// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MIPS memory stage: scalar typedefs, opcode
// constants, stage register layout and the memory-access state encoding.
package mem_stage_pkg;

  typedef logic [31:0] i32;
  typedef logic [5:0]  i6;
  typedef logic [4:0]  i5;
  typedef logic [3:0]  i4;
  typedef logic        i1;

  // Primary opcodes (instruction bits [31:26]); 0 doubles as the bubble icode.
  localparam i6 OP_SPECIAL = 6'h00;
  localparam i6 OP_ADDIU   = 6'h09;
  localparam i6 OP_LW      = 6'h23;
  localparam i6 OP_SW      = 6'h2b;

  // SPECIAL-group function codes.
  localparam i6 AC_ADDU    = 6'h21;
  localparam i6 AC_SUBU    = 6'h23;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  typedef struct packed {
    i32 pc;
    i32 val3;
    i32 valt;
    i6  icode;
    i5  dst;
    i4  strobe;
  } stage_regs_t;

  function automatic i1 is_mem_op(input i6 icode);
    return (icode == OP_LW) || (icode == OP_SW);
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Bus-access watchdog: counts cycles spent waiting on the data bus and raises
// a one-cycle expire pulse on the MAX_WAIT-th cycle, plus a sticky error flag.
module mem_watchdog #(
  parameter int MAX_WAIT = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire,
  output logic err
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] r_cnt;
  logic          r_err;

  // Fires during the cycle that brings the count to MAX_WAIT, so the stage
  // leaves REQ/WAIT after exactly MAX_WAIT stalled cycles.
  assign expire = en && (r_cnt == CW'(MAX_WAIT - 1));
  assign err    = r_err;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (clr) begin
        r_cnt <= '0;
      end else if (en) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (expire) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: holds execute results, runs LW/SW over a valid/addr_ok/
// data_ok data bus, stalls upstream while an access is outstanding.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int MAX_WAIT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] e_pc,
  input  logic [31:0] e_val3,
  input  logic [31:0] e_valt,
  input  logic [5:0]  e_icode,
  input  logic [4:0]  e_dst,
  input  logic [3:0]  e_req,
  input  logic        m_bubble,
  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [31:0] dresp_data,
  output logic        m_stall,
  output logic [31:0] m_pc,
  output logic [5:0]  m_icode,
  output logic [4:0]  m_dst,
  output logic [31:0] m_val,
  output logic        m_err
);

  stage_regs_t r_stage;
  mem_state_t  r_state;
  i32          r_wb;

  logic w_stall;
  logic w_advance;
  logic w_capture_mem;
  logic w_is_lw;
  logic w_expire;
  logic w_err;

  // NOTE: stall is decoded from registered state only, so no bus input has a
  // combinational path into the upstream hold logic.
  assign w_stall       = (r_state == REQ) || (r_state == WAIT);
  assign w_advance     = !w_stall;
  assign w_capture_mem = !m_bubble && is_mem_op(e_icode);
  assign w_is_lw       = (r_stage.icode == OP_LW);

  mem_watchdog #(
    .MAX_WAIT (MAX_WAIT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clr    (w_advance && w_capture_mem),
    .en     (w_stall),
    .expire (w_expire),
    .err    (w_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stage <= '0;
      r_state <= IDLE;
      r_wb    <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (m_bubble) begin
            r_stage <= '0;
          end else begin
            r_stage <= '{pc: e_pc, val3: e_val3, valt: e_valt,
                         icode: e_icode, dst: e_dst, strobe: e_req};
          end
          r_state <= w_capture_mem ? REQ : IDLE;
        end
        // data_ok without addr_ok belongs to no request of ours and is dropped.
        REQ: begin
          if (w_expire) begin
            r_state <= DONE;
            r_wb    <= '0;
          end else if (dresp_addr_ok && dresp_data_ok) begin
            r_state <= DONE;
            r_wb    <= w_is_lw ? dresp_data : r_stage.val3;
          end else if (dresp_addr_ok) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (w_expire) begin
            r_state <= DONE;
            r_wb    <= '0;
          end else if (dresp_data_ok) begin
            r_state <= DONE;
            r_wb    <= w_is_lw ? dresp_data : r_stage.val3;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dreq_valid  = (r_state == REQ);
  assign dreq_addr   = r_stage.val3;
  assign dreq_strobe = (r_stage.icode == OP_SW) ? r_stage.strobe : 4'h0;
  assign dreq_data   = r_stage.valt;

  assign m_stall = w_stall;
  assign m_pc    = r_stage.pc;
  assign m_icode = r_stage.icode;
  assign m_dst   = r_stage.dst;
  assign m_val   = (r_state == DONE) ? r_wb : r_stage.val3;
  assign m_err   = w_err;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table of instructions with scripted bus
// behaviour, scoreboarded write-back results, plus multi-cycle corner cases.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int MAXW = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] e_pc, e_val3, e_valt;
  logic [5:0]  e_icode;
  logic [4:0]  e_dst;
  logic [3:0]  e_req;
  logic        m_bubble;
  logic        dreq_valid;
  logic [31:0] dreq_addr, dreq_data;
  logic [3:0]  dreq_strobe;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [31:0] dresp_data;
  logic        m_stall, m_err;
  logic [31:0] m_pc, m_val;
  logic [5:0]  m_icode;
  logic [4:0]  m_dst;

  mem_stage #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset),
    .e_pc(e_pc), .e_val3(e_val3), .e_valt(e_valt), .e_icode(e_icode),
    .e_dst(e_dst), .e_req(e_req), .m_bubble(m_bubble),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_strobe(dreq_strobe),
    .dreq_data(dreq_data), .dresp_addr_ok(dresp_addr_ok),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .m_stall(m_stall), .m_pc(m_pc), .m_icode(m_icode), .m_dst(m_dst),
    .m_val(m_val), .m_err(m_err)
  );

  always #5 clk = ~clk;

  // Bus modes: 0 no access, 1 addr_ok+data_ok together, 2 addr_ok then
  // data_ok after n_wait idle WAIT cycles, 3 bus never answers.
  typedef struct {
    string       name;
    logic [5:0]  icode;
    logic [31:0] pc, val3, valt;
    logic [4:0]  dst;
    logic [3:0]  req;
    logic        bubble;
    int          n_noack;
    int          mode;
    int          n_wait;
    logic        stray;
    logic [31:0] rdata;
    logic [31:0] exp_val;
    int          exp_stall;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [5:0]  icode;
    logic [4:0]  dst;
    logic [31:0] val;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [5:0] icode,
      input logic [31:0] pc, input logic [31:0] val3, input logic [31:0] valt,
      input logic [4:0] dst, input logic [3:0] req, input logic bubble,
      input int n_noack, input int mode, input int n_wait, input logic stray,
      input logic [31:0] rdata, input logic [31:0] exp_val, input int exp_stall,
      input logic exp_err);
    vec_t v;
    v.name = name; v.icode = icode; v.pc = pc; v.val3 = val3; v.valt = valt;
    v.dst = dst; v.req = req; v.bubble = bubble; v.n_noack = n_noack;
    v.mode = mode; v.n_wait = n_wait; v.stray = stray; v.rdata = rdata;
    v.exp_val = exp_val; v.exp_stall = exp_stall; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic drive_instr(input logic [5:0] icode, input logic [31:0] pc,
      input logic [31:0] val3, input logic [31:0] valt, input logic [4:0] dst,
      input logic [3:0] req, input logic bubble);
    e_icode = icode; e_pc = pc; e_val3 = val3; e_valt = valt;
    e_dst = dst; e_req = req; m_bubble = bubble;
  endtask

  task automatic bus_idle();
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 32'h0;
  endtask

  // Entered and left at a negedge with the stage able to advance.
  task automatic run_vec(input vec_t v);
    exp_t e, got_e;
    int   c;
    int   bad;
    logic exp_valid;
    drive_instr(v.icode, v.pc, v.val3, v.valt, v.dst, v.req, v.bubble);
    e.pc    = v.bubble ? 32'h0 : v.pc;
    e.icode = v.bubble ? 6'h0  : v.icode;
    e.dst   = v.bubble ? 5'h0  : v.dst;
    e.val   = v.exp_val;
    e.err   = v.exp_err;
    sb.push_back(e);
    @(posedge clk);
    c   = 0;
    bad = 0;
    while (c < 64) begin
      @(negedge clk);
      if (!m_stall) break;
      exp_valid = (v.mode == 3) || (c <= v.n_noack);
      if (dreq_valid !== exp_valid) bad++;
      if (exp_valid && (dreq_addr !== v.val3 || dreq_data !== v.valt ||
                        dreq_strobe !== v.req)) bad++;
      dresp_addr_ok = 1'b0;
      dresp_data_ok = 1'b0;
      dresp_data    = 32'hBAD0_0000 | 32'(c);
      if (v.mode != 3) begin
        if (c < v.n_noack) begin
          dresp_data_ok = v.stray;
        end else if (c == v.n_noack) begin
          dresp_addr_ok = 1'b1;
          if (v.mode == 1) begin
            dresp_data_ok = 1'b1;
            dresp_data    = v.rdata;
          end
        end else if (v.mode == 2 && c == v.n_noack + 1 + v.n_wait) begin
          dresp_data_ok = 1'b1;
          dresp_data    = v.rdata;
        end
      end
      c++;
    end
    bus_idle();
    check({v.name, "/stall_cycles"}, c, v.exp_stall);
    check({v.name, "/dreq"}, bad, 0);
    check({v.name, "/sb_depth"}, sb.size(), 1);
    if (sb.size() != 0) begin
      got_e = sb.pop_front();
      check({v.name, "/m_pc"}, m_pc, got_e.pc);
      check({v.name, "/m_icode"}, m_icode, got_e.icode);
      check({v.name, "/m_dst"}, m_dst, got_e.dst);
      check({v.name, "/m_val"}, m_val, got_e.val);
      check({v.name, "/m_err"}, m_err, got_e.err);
    end
    check({v.name, "/dreq_valid_done"}, dreq_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t vecs[8];
    int   bad;
    vecs[0] = mk("addiu",      OP_ADDIU, 32'h1000, 32'h5,   32'h0,    5'd3, 4'h0, 1'b0, 0, 0, 0, 1'b0, 32'h0,        32'h5,        0, 1'b0);
    vecs[1] = mk("lw_fast",    OP_LW,    32'h1004, 32'h100, 32'h0,    5'd4, 4'h0, 1'b0, 0, 1, 0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1, 1'b0);
    vecs[2] = mk("sw_slow",    OP_SW,    32'h1008, 32'h200, 32'hCAFE, 5'd0, 4'hF, 1'b0, 3, 2, 1, 1'b0, 32'h0,        32'h200,      6, 1'b0);
    vecs[3] = mk("lw_stray",   OP_LW,    32'h100C, 32'h104, 32'h0,    5'd5, 4'h0, 1'b0, 2, 1, 0, 1'b1, 32'h12345678, 32'h12345678, 3, 1'b0);
    vecs[4] = mk("bubble_lw",  OP_LW,    32'h1010, 32'h108, 32'h0,    5'd9, 4'h0, 1'b1, 0, 0, 0, 1'b0, 32'h0,        32'h0,        0, 1'b0);
    vecs[5] = mk("lw_split",   OP_LW,    32'h1014, 32'h10C, 32'h0,    5'd6, 4'h0, 1'b0, 1, 2, 2, 1'b0, 32'hA5A50F0F, 32'hA5A50F0F, 5, 1'b0);
    vecs[6] = mk("addiu_ones", OP_ADDIU, 32'h1018, 32'hFFFFFFFF, 32'h0, 5'd0, 4'h0, 1'b0, 0, 0, 0, 1'b0, 32'h0,     32'hFFFFFFFF, 0, 1'b0);
    vecs[7] = mk("lw_timeout", OP_LW,    32'h101C, 32'h110, 32'h0,    5'd7, 4'h0, 1'b0, 0, 3, 0, 1'b0, 32'h0,        32'h0,        MAXW, 1'b1);

    reset = 1'b1;
    bus_idle();
    drive_instr(6'h0, 32'h0, 32'h0, 32'h0, 5'h0, 4'h0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst/dreq_valid", dreq_valid, 1'b0);
    check("rst/m_stall", m_stall, 1'b0);
    check("rst/m_err", m_err, 1'b0);
    check("rst/m_val", m_val, 32'h0);
    check("rst/m_icode", m_icode, 6'h0);
    check("rst/m_pc", m_pc, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Late response after a watchdog-forced DONE must not disturb anything.
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 32'h0BADF00D;
    drive_instr(OP_ADDIU, 32'h2000, 32'h77, 32'h0, 5'd9, 4'h0, 1'b0);
    @(negedge clk);
    check("late/m_stall", m_stall, 1'b0);
    check("late/m_val", m_val, 32'h77);
    check("late/m_err", m_err, 1'b1);
    check("late/dreq_valid", dreq_valid, 1'b0);
    bus_idle();

    // Bubble while stalled in WAIT is ignored; the later bubble is taken.
    drive_instr(OP_LW, 32'h3000, 32'h300, 32'h0, 5'd10, 4'h0, 1'b0);
    @(negedge clk);
    check("bub/req_stall", m_stall, 1'b1);
    dresp_addr_ok = 1'b1;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      dresp_addr_ok = 1'b0;
      if (m_pc !== 32'h3000 || m_icode !== OP_LW || m_dst !== 5'd10 ||
          dreq_valid !== 1'b0 || m_stall !== 1'b1) bad++;
      drive_instr(OP_SW, 32'hFFFF0000 | 32'(k), 32'h999, 32'h1, 5'd31, 4'hF, 1'b1);
      if (k == 3) begin
        dresp_data_ok = 1'b1;
        dresp_data    = 32'h0000BEEF;
      end
    end
    check("bub/held_in_wait", bad, 0);
    @(negedge clk);
    bus_idle();
    check("bub/done_stall", m_stall, 1'b0);
    check("bub/done_val", m_val, 32'h0000BEEF);
    check("bub/done_pc", m_pc, 32'h3000);
    @(negedge clk);
    check("bub/icode", m_icode, 6'h0);
    check("bub/dst", m_dst, 5'h0);
    check("bub/pc", m_pc, 32'h0);
    check("bub/stall", m_stall, 1'b0);

    // Asynchronous reset in the middle of WAIT.
    drive_instr(OP_LW, 32'h4000, 32'h400, 32'h0, 5'd11, 4'h0, 1'b0);
    @(negedge clk);
    check("arst/req_valid", dreq_valid, 1'b1);
    dresp_addr_ok = 1'b1;
    @(negedge clk);
    dresp_addr_ok = 1'b0;
    check("arst/wait_stall", m_stall, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("arst/dreq_valid", dreq_valid, 1'b0);
    check("arst/m_stall", m_stall, 1'b0);
    check("arst/m_pc", m_pc, 32'h0);
    check("arst/m_err", m_err, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    drive_instr(OP_ADDIU, 32'h5000, 32'h42, 32'h0, 5'd12, 4'h0, 1'b0);
    @(negedge clk);
    check("arst/after_val", m_val, 32'h42);
    check("arst/after_dst", m_dst, 5'd12);
    check("arst/after_stall", m_stall, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
